// File: rtl/bp_run_ctrl.sv
// Execution controller for the processor under debug. Gates the datapath
// enable in run-to-HALT, run-N-cycles or run-to-breakpoint mode, then freezes
// the pipeline and hands the enabled-cycle count to the send-data FSM.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for i_start, datapath frozen
// RUN       | datapath enabled until a stop condition fires
// DRAIN     | HALT seen in IF/ID, keep enabling until it retires through WB
// SEND      | one-cycle o_send_start pulse to the send-data FSM
// WAIT_SEND | frozen, count and cause held, waiting for i_send_done
// DONE      | one-cycle o_done pulse, then back to IDLE
module bp_run_ctrl #(
  parameter int unsigned                 PC_BITS          = 32,
  parameter int unsigned                 INSTRUCTION_BITS = 32,
  parameter int unsigned                 CLK_COUNTER_BITS = 32,
  parameter int unsigned                 STEP_BITS        = 16,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INST        = 32'hFFFF_FFFF,
  parameter int unsigned                 DRAIN_CYCLES     = 4,
  parameter logic [31:0]                 MAX_CYCLES       = 32'h00FF_FFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic [STEP_BITS-1:0]        i_step_count,
  input  logic [PC_BITS-1:0]          i_bp_addr,
  input  logic                        i_abort,
  input  logic [PC_BITS-1:0]          i_pc,
  input  logic [INSTRUCTION_BITS-1:0] i_instruction,
  input  logic                        i_send_done,
  output logic                        o_enable,
  output logic                        o_send_start,
  output logic [CLK_COUNTER_BITS-1:0] o_clk_count,
  output logic [1:0]                  o_stop_cause,
  output logic                        o_busy,
  output logic                        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SEND,
    S_WAIT_SEND,
    S_DONE
  } state_t;

  localparam logic [1:0] CAUSE_HALT  = 2'd0;
  localparam logic [1:0] CAUSE_STEPS = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_ABORT = 2'd3;

  localparam logic [1:0] MODE_STEPS = 2'd1;
  localparam logic [1:0] MODE_BP    = 2'd2;

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  // Drain counter value on the last enabled drain cycle; the HALT-detect
  // cycle itself loads the counter with 1.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  localparam logic [CLK_COUNTER_BITS-1:0] MAX_CNT = CLK_COUNTER_BITS'(MAX_CYCLES);
  localparam logic [CLK_COUNTER_BITS-1:0] CNT_SAT = '1;

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             mode_q;
  logic [STEP_BITS-1:0]   step_n_q;
  logic [STEP_BITS-1:0]   step_cnt;
  logic [PC_BITS-1:0]     bp_q;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic                   first_q;
  logic [1:0]             cause_nxt;
  logic                   drain_load;
  logic                   halt_seen;
  logic                   bp_hit;
  logic                   step_hit;
  logic                   tmo_hit;

  // Stop-condition decode, next state and the combinational datapath enable.
  always_comb begin
    halt_seen  = (i_instruction == HALT_INST);
    bp_hit     = (mode_q == MODE_BP) && first_q && (i_pc == bp_q);
    step_hit   = (mode_q == MODE_STEPS) && (step_cnt == step_n_q);
    tmo_hit    = (o_clk_count == MAX_CNT);
    state_nxt  = state;
    cause_nxt  = o_stop_cause;
    o_enable   = 1'b0;
    drain_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_RUN;
          cause_nxt = CAUSE_HALT;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          cause_nxt = CAUSE_ABORT;
          state_nxt = S_SEND;
        end else if (halt_seen) begin
          // HALT must still advance through the pipe, so this cycle is enabled
          o_enable   = 1'b1;
          drain_load = 1'b1;
          cause_nxt  = CAUSE_HALT;
          state_nxt  = (DRAIN_CYCLES > 1) ? S_DRAIN : S_SEND;
        end else if (bp_hit) begin
          cause_nxt = CAUSE_BP;
          state_nxt = S_SEND;
        end else if (step_hit) begin
          cause_nxt = CAUSE_STEPS;
          state_nxt = S_SEND;
        end else if (tmo_hit) begin
          cause_nxt = CAUSE_ABORT;
          state_nxt = S_SEND;
        end else begin
          o_enable = 1'b1;
        end
      end
      S_DRAIN: begin
        o_enable = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        state_nxt = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (i_send_done) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, latched run operands, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      mode_q       <= '0;
      step_n_q     <= '0;
      step_cnt     <= '0;
      bp_q         <= '0;
      drain_cnt    <= '0;
      first_q      <= 1'b0;
      o_clk_count  <= '0;
      o_stop_cause <= '0;
      o_send_start <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_stop_cause <= cause_nxt;
      o_busy       <= (state_nxt != S_IDLE);
      o_send_start <= (state_nxt == S_SEND);
      o_done       <= (state_nxt == S_DONE);

      if (state == S_IDLE && i_start) begin
        mode_q      <= i_mode;
        step_n_q    <= (i_step_count == '0) ? STEP_BITS'(1) : i_step_count;
        bp_q        <= i_bp_addr;
        o_clk_count <= '0;
        step_cnt    <= '0;
        drain_cnt   <= '0;
        first_q     <= 1'b0;
      end else begin
        if (o_enable) begin
          o_clk_count <= (o_clk_count == CNT_SAT) ? o_clk_count : o_clk_count + 1'b1;
          step_cnt    <= step_cnt + 1'b1;
          first_q     <= 1'b1;
        end
        if (drain_load) begin
          drain_cnt <= DRAIN_W'(1);
        end else if (state == S_DRAIN) begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_run_ctrl.sv
// Directed bench for bp_run_ctrl. A stimulus process issues runs and pushes
// the expected count/cause into a scoreboard; a monitor pops and compares on
// each o_send_start pulse. The IF/ID stage is modelled as a PC that advances
// by 4 per enabled cycle, with HALT placed at a chosen PC.
module tb_bp_run_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [15:0] i_step_count;
  logic [31:0] i_bp_addr;
  logic        i_abort;
  logic [31:0] i_pc;
  logic [31:0] i_instruction;
  logic        i_send_done;
  logic        o_enable;
  logic        o_send_start;
  logic [31:0] o_clk_count;
  logic [1:0]  o_stop_cause;
  logic        o_busy;
  logic        o_done;

  typedef struct {
    logic [31:0] count;
    logic [1:0]  cause;
    int          en;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  int          en_cycles;
  int          en_base;
  int          done_cnt;
  bit          overlap;
  string       label;
  logic [31:0] pc0;
  bit          adv;
  bit          halt_on;
  logic [31:0] halt_pc;

  bp_run_ctrl #(
    .MAX_CYCLES(32'd16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_step_count (i_step_count),
    .i_bp_addr    (i_bp_addr),
    .i_abort      (i_abort),
    .i_pc         (i_pc),
    .i_instruction(i_instruction),
    .i_send_done  (i_send_done),
    .o_enable     (o_enable),
    .o_send_start (o_send_start),
    .o_clk_count  (o_clk_count),
    .o_stop_cause (o_stop_cause),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_pc          = pc0 + (adv ? 32'(en_cycles - en_base) * 32'd4 : 32'd0);
  assign i_instruction = (halt_on && i_pc == halt_pc) ? HALT : NOP;

  // enabled-cycle counter seen by the IF/ID model
  always @(posedge clk) begin
    if (o_enable) en_cycles <= en_cycles + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", label, name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (o_send_start) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/unexpected_send_start: got pulse expected none", label);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("clk_count", 64'(o_clk_count), 64'(e.count));
        check("stop_cause", 64'(o_stop_cause), 64'(e.cause));
        check("enabled_cycles", 64'(en_cycles - en_base), 64'(e.en));
      end
    end
    if (o_done) done_cnt++;
    if (o_done && o_send_start) overlap = 1'b1;
  end

  task automatic run_case(input string name, input logic [1:0] mode, input logic [15:0] n,
                          input logic [31:0] bp, input logic [31:0] pc_start, input bit advance,
                          input bit halt_en_i, input logic [31:0] halt_at, input int abort_at,
                          input int exp_count, input logic [1:0] exp_cause, input bit rst_in_wait);
    exp_t e;
    int   cyc;
    int   done_before;
    label        = name;
    pc0          = pc_start;
    adv          = advance;
    halt_on      = halt_en_i;
    halt_pc      = halt_at;
    i_mode       = mode;
    i_step_count = n;
    i_bp_addr    = bp;
    e.count      = 32'(exp_count);
    e.cause      = exp_cause;
    e.en         = exp_count;
    sb_q.push_back(e);
    en_base = en_cycles;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_in_run", 64'(o_busy), 64'd1);
    cyc = 1;
    while (!o_send_start && cyc < 200) begin
      i_abort = (cyc == abort_at);
      @(posedge clk); #1;
      cyc++;
    end
    i_abort = 1'b0;
    check("send_start_seen", 64'(o_send_start), 64'd1);
    @(posedge clk); #1;
    check("enable_in_wait", 64'(o_enable), 64'd0);
    if (rst_in_wait) begin
      done_before = done_cnt;
      i_send_done = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("outputs_after_reset",
            64'({o_enable, o_send_start, o_busy, o_done, o_stop_cause, o_clk_count}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      i_send_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_done_after_reset", 64'(done_cnt - done_before), 64'd0);
      check("idle_after_reset", 64'(o_busy), 64'd0);
    end else begin
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      done_before = done_cnt;
      i_send_done = 1'b1;
      @(posedge clk); #1;
      i_send_done = 1'b0;
      check("done_pulse", 64'(o_done), 64'd1);
      @(posedge clk); #1;
      check("done_cleared", 64'(o_done), 64'd0);
      check("done_count", 64'(done_cnt - done_before), 64'd1);
      check("idle_after_done", 64'(o_busy), 64'd0);
      check("count_held", 64'(o_clk_count), 64'(exp_count));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    en_cycles    = 0;
    en_base      = 0;
    done_cnt     = 0;
    overlap      = 1'b0;
    label        = "reset";
    pc0          = '0;
    adv          = 1'b0;
    halt_on      = 1'b0;
    halt_pc      = '0;
    rst          = 1'b0;
    i_start      = 1'b0;
    i_mode       = '0;
    i_step_count = '0;
    i_bp_addr    = '0;
    i_abort      = 1'b0;
    i_send_done  = 1'b0;
    #12;
    check("reset_state",
          64'({o_enable, o_send_start, o_busy, o_done, o_stop_cause, o_clk_count}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    //        name                 mode  N      bp        pc0       adv halt halt_pc  abort cnt cause rstw
    run_case("halt_mode0",        2'd0, 16'd0, 32'h0,    32'h0,    1,  1,   32'h24,  0,    13, 2'd0, 0);
    run_case("steps_n5",          2'd1, 16'd5, 32'h0,    32'h0,    1,  0,   32'h0,   0,    5,  2'd1, 0);
    run_case("steps_n0",          2'd1, 16'd0, 32'h0,    32'h0,    1,  0,   32'h0,   0,    1,  2'd1, 0);
    run_case("bp_0x20",           2'd2, 16'd0, 32'h20,   32'h0,    1,  0,   32'h0,   0,    8,  2'd2, 0);
    run_case("bp_resume",         2'd2, 16'd0, 32'h20,   32'h20,   0,  0,   32'h0,   0,    1,  2'd2, 0);
    run_case("halt_vs_bp",        2'd2, 16'd0, 32'h10,   32'h0,    1,  1,   32'h10,  0,    8,  2'd0, 0);
    run_case("abort_run",         2'd0, 16'd0, 32'h0,    32'h0,    1,  0,   32'h0,   3,    2,  2'd3, 0);
    run_case("timeout",           2'd0, 16'd0, 32'h0,    32'h0,    1,  0,   32'h0,   0,    16, 2'd3, 0);
    run_case("mode3_abort_drain", 2'd3, 16'd0, 32'h4,    32'h0,    1,  1,   32'h8,   5,    6,  2'd0, 0);
    run_case("rst_in_wait",       2'd1, 16'd3, 32'h0,    32'h0,    1,  0,   32'h0,   0,    3,  2'd1, 1);
    run_case("after_reset",       2'd1, 16'd5, 32'h0,    32'h0,    1,  0,   32'h0,   0,    5,  2'd1, 0);

    label = "final";
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("send_done_overlap", 64'(overlap), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_run_ctrl.md
Name: bp_run_ctrl

Overview:
Execution controller for the pipelined processor under debug. On command it gates the datapath enable in one of three modes: run-to-HALT, run-N-cycles, or run-to-breakpoint. On stop it holds the pipeline frozen and hands a cycle count to the send-data FSM for upload. It sits beside the debug top-level FSM, which selects it in place of the plain run controller when a breakpoint/step command arrives.

Parameters:
PC_BITS, 32, program counter width
INSTRUCTION_BITS, 32, instruction width
CLK_COUNTER_BITS, 32, enabled-cycle counter width
STEP_BITS, 16, step-count operand width
HALT_INST, 32'hFFFFFFFF, encoding of the HALT instruction
DRAIN_CYCLES, 4, extra enabled cycles after HALT is seen in IF/ID, so HALT reaches WB
MAX_CYCLES, 32'h00FF_FFFF, timeout limit on enabled cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_mode  in  2  0=run to HALT, 1=run N cycles, 2=run to breakpoint, 3=reserved (treated as 0)
i_step_count  in  STEP_BITS  N for mode 1; value 0 is treated as 1
i_bp_addr  in  PC_BITS  breakpoint PC for mode 2
i_abort  in  1  host abort request
i_pc  in  PC_BITS  PC of the instruction in IF/ID
i_instruction  in  INSTRUCTION_BITS  instruction in IF/ID
i_send_done  in  1  completion from the send-data FSM
o_enable  out  1  datapath enable
o_send_start  out  1  one-cycle pulse to the send-data FSM
o_clk_count  out  CLK_COUNTER_BITS  enabled cycles since start
o_stop_cause  out  2  0=HALT, 1=steps, 2=breakpoint, 3=timeout/abort
o_busy  out  1  high whenever the state is not IDLE
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs are 0.
  - Mode, step, breakpoint registers and counters are 0.
- IDLE:
  - o_enable=0.
  - When i_start=1: latch i_mode, max(i_step_count,1) and i_bp_addr; clear o_clk_count, step counter, drain counter and first-cycle flag; go to RUN the next cycle.
- RUN:
  - o_enable is combinational: 1 unless a stop condition is true this cycle.
  - Each cycle with o_enable=1 increments o_clk_count (saturating at max) and the step counter, and sets the first-cycle flag.
  - Stop conditions are checked in priority order; the first true one wins:
    1. i_abort → cause 3, o_enable=0, go to SEND.
    2. i_instruction==HALT_INST (any mode) → cause 0, go to DRAIN. o_enable=1 this cycle, and the cycle counts toward the drain.
    3. Mode 2, first-cycle flag set and i_pc==bp → cause 2, o_enable=0, go to SEND. The breakpoint is not taken on the very first cycle, so resuming from a breakpoint PC works.
    4. Mode 1 and step counter == latched N → cause 1, o_enable=0, go to SEND. Exactly N enabled cycles have then occurred.
    5. o_clk_count == MAX_CYCLES → cause 3, o_enable=0, go to SEND.
- DRAIN:
  - o_enable=1 for a total of DRAIN_CYCLES enabled cycles, counting the HALT-detect cycle; o_clk_count keeps incrementing.
  - Then go to SEND with o_enable=0.
  - i_abort in DRAIN: drain completes anyway; cause stays 0.
- SEND: o_enable=0; o_send_start=1 for exactly one cycle; next state is WAIT_SEND.
- WAIT_SEND:
  - o_enable=0; hold o_clk_count and o_stop_cause stable.
  - On i_send_done, go to DONE.
  - i_abort is ignored.
- DONE: o_done=1 for one cycle; go to IDLE. o_clk_count and o_stop_cause hold until the next i_start.
- i_start outside IDLE is ignored.
- o_send_start and o_done are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No o_done and no o_send_start are generated.

Test Plan:
- Mode 0, HALT_INST appears in IF/ID on the 10th enabled cycle → o_enable high for 10+3=13 cycles, o_clk_count=13, cause 0, one o_send_start pulse; after i_send_done, one o_done pulse.
- Mode 1, N=5 → exactly 5 enabled cycles, o_clk_count=5, cause 1. Repeat with N=0 → 1 enabled cycle.
- Mode 2, bp=0x20, i_pc sequence 0x0, 0x4, …, 0x20 → enable drops in the cycle i_pc=0x20, o_clk_count=8, cause 2. Restart with i_pc already 0x20 → at least one enabled cycle before any stop.
- Simultaneous HALT_INST and bp match in the same cycle (mode 2) → HALT wins: DRAIN entered, cause 0.
- i_abort asserted mid-RUN in cycle 3 → o_enable=0 that cycle, cause 3, send sequence and o_done follow. Timeout run with MAX_CYCLES overridden to 16 → o_clk_count=16, cause 3.
- rst pulsed low while in WAIT_SEND → all outputs 0 immediately, no o_done; a following i_start runs normally.
